// File: rtl/mbox_seq_pkg.sv
// mbox_seq_pkg
// Shared definitions for the Math Box program sequencer: default widths,
// watchdog limit and the sequencer state encoding.
// No ports (package).
package mbox_seq_pkg;

    localparam int DEF_PC_W     = 8;     // microcode PC / ROM address width
    localparam int DEF_CMD_W    = 5;     // CPU command (start-PROM index) width
    localparam int WDOG_W       = 10;    // watchdog counter width
    localparam int DEF_WDOG_MAX = 1023;  // RUN cycles before forced termination

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        LOAD   = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/mbox_watchdog.sv
// mbox_watchdog
// RUN-cycle watchdog for the Math Box sequencer. The count is cleared while
// the program start address is loaded and advances on every RUN cycle that
// actually executes a microword.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   i_clear  in   zero the count
//   i_en     in   count this cycle
//   o_hit    out  this cycle's increment brings the count to MAX
module mbox_watchdog
    import mbox_seq_pkg::*;
#(
    parameter int W   = WDOG_W,
    parameter int MAX = DEF_WDOG_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_hit
);

    // Terminal count is one below MAX: the cycle that increments the count
    // to MAX is the MAX-th executed RUN cycle, which is when the program is
    // forced to terminate.
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_hit = i_en && (r_count == LAST);

endmodule

// File: rtl/mbox_pc_sequencer.sv
// mbox_pc_sequencer
// Math Box program sequencer: accepts CPU command writes, looks up the
// microprogram start address, and steps / jumps / stops the microcode PC.
// Optional single-step support is built when MBOX_STEP_EN is defined.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   step_mode, step      (MBOX_STEP_EN only) single-step control
//   cmd_wr, cmd_addr     CPU command write strobe and command code
//   start_addr           registered index into the start-address PROM
//   start_pc             PROM data, valid one cycle after start_addr changes
//   pcen_n, jump_pc      0 = load jump_pc (from PC-enable control / microword)
//   stop                 microword stop bit
//   pc                   microcode ROM address
//   begin_n              low for the single cycle the start PC is loaded
//   busy, done           busy from accept until end, one-cycle done pulse
//   timeout, cmd_overrun sticky status, cleared by the next accepted command
module mbox_pc_sequencer
    import mbox_seq_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int CMD_W    = DEF_CMD_W,
    parameter int WDOG_MAX = DEF_WDOG_MAX
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MBOX_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    input  logic             cmd_wr,
    input  logic [CMD_W-1:0] cmd_addr,
    output logic [CMD_W-1:0] start_addr,
    input  logic [PC_W-1:0]  start_pc,
    input  logic             pcen_n,
    input  logic [PC_W-1:0]  jump_pc,
    input  logic             stop,
    output logic [PC_W-1:0]  pc,
    output logic             begin_n,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             cmd_overrun
);

    seq_state_t       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CMD_W-1:0] r_start_addr;
    logic             r_begin_n;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic             r_cmd_overrun;

    logic             w_advance;
    logic             w_wdog_hit;

    // A RUN cycle that does not advance holds PC, stop evaluation and watchdog.
`ifdef MBOX_STEP_EN
    assign w_advance = (r_state == RUN) && (!step_mode || step);
`else
    assign w_advance = (r_state == RUN);
`endif

    mbox_watchdog #(
        .W   (WDOG_W),
        .MAX (WDOG_MAX)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state == LOAD),
        .i_en    (w_advance),
        .o_hit   (w_wdog_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_start_addr  <= '0;
            r_begin_n     <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cmd_overrun <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_begin_n <= 1'b1;
            case (r_state)
                IDLE, DONE: begin
                    if (cmd_wr) begin
                        r_start_addr  <= cmd_addr;
                        r_timeout     <= 1'b0;
                        r_cmd_overrun <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= LOOKUP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                LOOKUP: begin
                    // begin_n is registered, so drop it on entry to LOAD
                    r_begin_n <= 1'b0;
                    r_state   <= LOAD;
                end
                LOAD: begin
                    r_pc    <= start_pc;
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_advance) begin
                        if (stop) begin
                            // stop also beats a watchdog hit in the same cycle
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc <= pcen_n ? r_pc + 1'b1 : jump_pc;
                            if (w_wdog_hit) begin
                                r_timeout <= 1'b1;
                                r_state   <= DONE;
                                r_done    <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (cmd_wr && (r_state == LOOKUP || r_state == LOAD || r_state == RUN)) begin
                r_cmd_overrun <= 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign start_addr  = r_start_addr;
    assign begin_n     = r_begin_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cmd_overrun = r_cmd_overrun;

endmodule

// File: tb/tb_mbox_pc_sequencer.sv
module tb_mbox_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_wr;
    logic [4:0] cmd_addr;
    logic [4:0] start_addr;
    logic [7:0] start_pc;
    logic       pcen_n;
    logic [7:0] jump_pc;
    logic       stop;
    logic [7:0] pc;
    logic       begin_n;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       cmd_overrun;
`ifdef MBOX_STEP_EN
    logic       step_mode = 1'b0;
    logic       step      = 1'b0;
`endif

    always #5 clk = ~clk;

    mbox_pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
`ifdef MBOX_STEP_EN
        .step_mode   (step_mode),
        .step        (step),
`endif
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .start_addr  (start_addr),
        .start_pc    (start_pc),
        .pcen_n      (pcen_n),
        .jump_pc     (jump_pc),
        .stop        (stop),
        .pc          (pc),
        .begin_n     (begin_n),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cmd_overrun (cmd_overrun)
    );

    // Microcode ROM (combinational on pc) and registered start-address PROM
    bit         rom_stop   [256];
    bit         rom_pcen_n [256];
    logic [7:0] rom_jump   [256];
    logic [7:0] prom       [32];
    logic       stop_man;

    always_comb begin
        stop    = rom_stop[pc] | stop_man;
        pcen_n  = rom_pcen_n[pc];
        jump_pc = rom_jump[pc];
    end

    always @(posedge clk) start_pc <= prom[start_addr];

    int n_checks = 0;
    int n_pass   = 0;

    // Expected program trace: RUN-cycle PCs, cycle count, timeout, PC in DONE
    logic [7:0] exp_pc [1023];
    int         exp_n;
    bit         exp_to;
    logic [7:0] exp_final;

    typedef struct {
        logic [4:0]      cmd;
        logic [7:0]      spc;
        logic [7:0]      stp;
        bit              jen;
        logic [7:0]      jfrom;
        logic [7:0]      jto;
        int              inj;
        bit              b2b;
        int              n;
        logic [5:0][7:0] pcs;   // written {p0,p1,...,p5}
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_rom();
        for (int p = 0; p < 256; p++) begin
            rom_stop[p]   = 1'b0;
            rom_pcen_n[p] = 1'b1;
            rom_jump[p]   = 8'h00;
        end
    endtask

    // Walk the microprogram by its rules: stop ends on the current PC,
    // otherwise jump or step; 1023 executed cycles without stop is a timeout.
    task automatic model(input logic [7:0] spc, input int stop_at);
        logic [7:0] p;
        p      = spc;
        exp_to = 1'b1;
        exp_n  = 1023;
        for (int k = 0; k < 1023; k++) begin
            exp_pc[k] = p;
            if (rom_stop[p] || (k + 1 == stop_at)) begin
                exp_n     = k + 1;
                exp_to    = 1'b0;
                exp_final = p;
                return;
            end
            p = rom_pcen_n[p] ? p + 8'd1 : rom_jump[p];
        end
        exp_final = p;
    endtask

    // Called at a negedge with the DUT in IDLE or DONE. Returns at the DONE
    // negedge when b2b is set, else at the following IDLE negedge.
    task automatic run_prog(input logic [4:0] c, input int inj, input int stop_at, input bit b2b);
        cmd_wr   = 1'b1;
        cmd_addr = c;
        @(negedge clk);
        cmd_wr   = 1'b0;
        cmd_addr = 5'($urandom);
        chk("lookup_busy", 32'(busy), 32'd1);
        chk("lookup_begin_n", 32'(begin_n), 32'd1);
        chk("lookup_start_addr", 32'(start_addr), 32'(c));
        chk("lookup_overrun_cleared", 32'(cmd_overrun), 32'd0);
        chk("lookup_timeout_cleared", 32'(timeout), 32'd0);
        @(negedge clk);
        chk("load_begin_n", 32'(begin_n), 32'd0);
        chk("load_done", 32'(done), 32'd0);
        for (int k = 1; k <= exp_n; k++) begin
            @(negedge clk);
            chk($sformatf("run_pc[%0d]", k), 32'(pc), 32'(exp_pc[k-1]));
            if (k == 1) begin
                chk("run_begin_n", 32'(begin_n), 32'd1);
                chk("run_busy", 32'(busy), 32'd1);
            end
            if (k == exp_n) chk("run_done_low", 32'(done), 32'd0);
            stop_man = (k == stop_at);
            cmd_wr   = (k == inj);
            if (k == inj) cmd_addr = ~c;
        end
        @(negedge clk);
        stop_man = 1'b0;
        cmd_wr   = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_pc", 32'(pc), 32'(exp_final));
        chk("done_timeout", 32'(timeout), 32'(exp_to));
        chk("done_overrun", 32'(cmd_overrun), 32'(inj > 0));
        chk("done_start_addr", 32'(start_addr), 32'(c));
        chk("done_begin_n", 32'(begin_n), 32'd1);
        if (!b2b) begin
            @(negedge clk);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_pc", 32'(pc), 32'(exp_final));
            chk("idle_timeout", 32'(timeout), 32'(exp_to));
            chk("idle_overrun", 32'(cmd_overrun), 32'(inj > 0));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        logic [4:0] c;
        int         inj;
        bit         b2b;

        vecs[0] = '{cmd:5'h03, spc:8'h40, stp:8'h43, jen:1'b0, jfrom:8'h00, jto:8'h00,
                    inj:2, b2b:1'b0, n:4, pcs:{8'h40, 8'h41, 8'h42, 8'h43, 8'h00, 8'h00}};
        vecs[1] = '{cmd:5'h07, spc:8'h10, stp:8'h81, jen:1'b1, jfrom:8'h10, jto:8'h80,
                    inj:0, b2b:1'b1, n:3, pcs:{8'h10, 8'h80, 8'h81, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{cmd:5'h1F, spc:8'hFE, stp:8'h01, jen:1'b0, jfrom:8'h00, jto:8'h00,
                    inj:0, b2b:1'b0, n:4, pcs:{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00}};
        vecs[3] = '{cmd:5'h00, spc:8'h55, stp:8'h55, jen:1'b0, jfrom:8'h00, jto:8'h00,
                    inj:1, b2b:1'b1, n:1, pcs:{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{cmd:5'h12, spc:8'h20, stp:8'hF1, jen:1'b1, jfrom:8'h22, jto:8'hF0,
                    inj:0, b2b:1'b0, n:5, pcs:{8'h20, 8'h21, 8'h22, 8'hF0, 8'hF1, 8'h00}};

        reset    = 1'b1;
        cmd_wr   = 1'b0;
        cmd_addr = 5'h00;
        stop_man = 1'b0;
        clear_rom();
        for (int i = 0; i < 32; i++) prom[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_start_addr", 32'(start_addr), 32'd0);
        chk("reset_begin_n", 32'(begin_n), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);
        chk("reset_overrun", 32'(cmd_overrun), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            clear_rom();
            rom_stop[vecs[v].stp] = 1'b1;
            if (vecs[v].jen) begin
                rom_pcen_n[vecs[v].jfrom] = 1'b0;
                rom_jump[vecs[v].jfrom]   = vecs[v].jto;
            end
            prom[vecs[v].cmd] = vecs[v].spc;
            exp_n  = vecs[v].n;
            exp_to = 1'b0;
            for (int i = 0; i < vecs[v].n; i++) exp_pc[i] = vecs[v].pcs[5-i];
            exp_final = vecs[v].pcs[5-(vecs[v].n-1)];
            run_prog(vecs[v].cmd, vecs[v].inj, 0, vecs[v].b2b);
        end

        // Watchdog: no stop at all, then stop on the 1023rd RUN cycle
        clear_rom();
        prom[5'h09] = 8'hC0;
        model(8'hC0, 0);
        run_prog(5'h09, 0, 0, 1'b1);
        model(8'hC0, 1023);
        run_prog(5'h09, 0, 1023, 1'b0);

        // Reset in the middle of RUN
        clear_rom();
        prom[5'h02] = 8'h30;
        cmd_wr   = 1'b1;
        cmd_addr = 5'h02;
        @(negedge clk);
        cmd_wr = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_pc", 32'(pc), 32'h32);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_reset_pc", 32'(pc), 32'd0);
        chk("midrun_reset_start_addr", 32'(start_addr), 32'd0);
        chk("midrun_reset_begin_n", 32'(begin_n), 32'd1);
        chk("midrun_reset_busy", 32'(busy), 32'd0);
        chk("midrun_reset_done", 32'(done), 32'd0);
        chk("midrun_reset_timeout", 32'(timeout), 32'd0);
        chk("midrun_reset_overrun", 32'(cmd_overrun), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_reset_done", 32'(done), 32'd0);
            chk("after_reset_pc", 32'(pc), 32'd0);
        end

        // Randomized microprograms against the trace model
        for (int it = 0; it < 25; it++) begin
            for (int p = 0; p < 256; p++) begin
                rom_stop[p]   = ($urandom_range(0, 15) == 0);
                rom_pcen_n[p] = ($urandom_range(0, 3) != 0);
                rom_jump[p]   = 8'($urandom);
            end
            for (int i = 0; i < 32; i++) prom[i] = 8'($urandom);
            c = 5'($urandom);
            model(prom[c], 0);
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, exp_n)) : 0;
            b2b = 1'($urandom_range(0, 1));
            run_prog(c, inj, 0, b2b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
